// File: rtl/vector_operand_loader.sv
// Producer side of the Vector_Multiplier operand interface: assembles a serial stream of
// (weight, feature) pairs into the multiplier's operand arrays and returns the registered dot product.
module vector_operand_loader #(
    parameter int  VEC_LEN = 96,
    parameter int  ELEM_W  = 5,
    parameter int  PROD_W  = 16,
    localparam int CNT_W   = $clog2(VEC_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_weight,
    input  logic [ELEM_W-1:0] in_feature,
    input  logic              in_last,
    output logic [ELEM_W-1:0] weight_vec  [VEC_LEN],
    output logic [ELEM_W-1:0] feature_vec [VEC_LEN],
    input  logic [PROD_W-1:0] mult_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_data,
    output logic              out_short
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [ELEM_W-1:0]   weight_q  [VEC_LEN];
    logic [ELEM_W-1:0]   weight_d  [VEC_LEN];
    logic [ELEM_W-1:0]   feature_q [VEC_LEN];
    logic [ELEM_W-1:0]   feature_d [VEC_LEN];
    logic                out_valid_q, out_valid_d;
    logic [PROD_W-1:0]   out_data_q, out_data_d;
    logic                out_short_q, out_short_d;

    // Next-state, element capture, result capture and the post-handoff clear.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        weight_d    = weight_q;
        feature_d   = feature_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_short_d = out_short_q;
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    weight_d[idx_q]  = in_weight;
                    feature_d[idx_q] = in_feature;
                    idx_d            = idx_q + CNT_W'(1);
                    if (in_last || (idx_q == LAST_IDX)) begin
                        state_d     = EVAL;
                        out_short_d = (idx_q != LAST_IDX);
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            EVAL: begin
                // Operand arrays are stable here, so the combinational product has settled.
                out_data_d  = mult_product;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    idx_d       = {CNT_W{1'b0}};
                    for (int i = 0; i < VEC_LEN; i++) begin
                        weight_d[i]  = {ELEM_W{1'b0}};
                        feature_d[i] = {ELEM_W{1'b0}};
                    end
                    state_d = FILL;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            idx_q       <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {PROD_W{1'b0}};
            out_short_q <= 1'b0;
            for (int i = 0; i < VEC_LEN; i++) begin
                weight_q[i]  <= {ELEM_W{1'b0}};
                feature_q[i] <= {ELEM_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_short_q <= out_short_d;
            weight_q    <= weight_d;
            feature_q   <= feature_d;
        end
    end

    assign in_ready    = (state_q == FILL);
    assign weight_vec  = weight_q;
    assign feature_vec = feature_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_short   = out_short_q;

endmodule

// File: tb/tb_vector_operand_loader.sv
// Directed bench for vector_operand_loader: table of vectors with hand-computed dot products,
// plus backpressure and mid-operation reset sequences. A behavioural dot product stands in for the multiplier.
module tb_vector_operand_loader;

    localparam int VEC_LEN = 96;
    localparam int ELEM_W  = 5;
    localparam int PROD_W  = 16;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] in_weight;
    logic [ELEM_W-1:0] in_feature;
    logic              in_last;
    logic [ELEM_W-1:0] weight_vec  [VEC_LEN];
    logic [ELEM_W-1:0] feature_vec [VEC_LEN];
    logic [PROD_W-1:0] mult_product;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] out_data;
    logic              out_short;

    int n_cmp;
    int n_bad;

    vector_operand_loader #(
        .VEC_LEN(VEC_LEN),
        .ELEM_W (ELEM_W),
        .PROD_W (PROD_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_weight   (in_weight),
        .in_feature  (in_feature),
        .in_last     (in_last),
        .weight_vec  (weight_vec),
        .feature_vec (feature_vec),
        .mult_product(mult_product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_short   (out_short)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the combinational Vector_Multiplier.
    always_comb begin
        int acc;
        acc = 0;
        for (int i = 0; i < VEC_LEN; i++) begin
            acc = acc + int'(weight_vec[i]) * int'(feature_vec[i]);
        end
        mult_product = acc[PROD_W-1:0];
    end

    typedef struct {
        int n;
        int wb;
        int ws;
        int fb;
        int fs;
        bit use_last;
        bit bubbles;
        int exp_data;
        bit exp_short;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [ELEM_W-1:0] w, input logic [ELEM_W-1:0] f, input bit last);
        int waited;
        in_valid   = 1'b1;
        in_weight  = w;
        in_feature = f;
        in_last    = last;
        waited     = 0;
        while (!in_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("release_in_ready", int'(in_ready), 1);
        check("release_out_valid", int'(out_valid), 0);
    endtask

    task automatic run_vector(input vec_t v, input bit do_release);
        for (int i = 0; i < v.n; i++) begin
            if (v.bubbles && (i % 2 == 1)) begin
                in_valid = 1'b0;
                step();
            end
            send(ELEM_W'(v.wb + i * v.ws), ELEM_W'(v.fb + i * v.fs), v.use_last && (i == v.n - 1));
        end
        // One cycle in EVAL, then the result is presented.
        check("eval_in_ready", int'(in_ready), 0);
        check("eval_out_valid", int'(out_valid), 0);
        step();
        check("out_valid", int'(out_valid), 1);
        check("out_data", int'(out_data), v.exp_data);
        check("out_short", int'(out_short), int'(v.exp_short));
        if (do_release) release_out();
    endtask

    initial begin
        int held;
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_weight  = '0;
        in_feature = '0;
        in_last    = 1'b0;
        out_ready  = 1'b0;

        //              n   wb ws fb fs last bub  data   short
        tbl[0] = '{n:96, wb:0, ws:1, fb:1, fs:1, use_last:1, bubbles:0, exp_data:29760, exp_short:0};
        tbl[1] = '{n:96, wb:1, ws:0, fb:1, fs:0, use_last:0, bubbles:0, exp_data:96,    exp_short:0};
        tbl[2] = '{n:4,  wb:1, ws:2, fb:2, fs:2, use_last:1, bubbles:0, exp_data:100,   exp_short:1};
        tbl[3] = '{n:96, wb:1, ws:0, fb:1, fs:0, use_last:0, bubbles:0, exp_data:96,    exp_short:0};
        tbl[4] = '{n:96, wb:0, ws:1, fb:1, fs:1, use_last:1, bubbles:1, exp_data:29760, exp_short:0};
        tbl[5] = '{n:95, wb:1, ws:0, fb:1, fs:0, use_last:1, bubbles:0, exp_data:95,    exp_short:1};
        tbl[6] = '{n:1,  wb:31, ws:0, fb:31, fs:0, use_last:1, bubbles:0, exp_data:961, exp_short:1};

        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_short", int'(out_short), 0);
        check("rst_vectors_zero", int'(mult_product), 0);

        for (int k = 0; k < 7; k++) begin
            run_vector(tbl[k], 1'b1);
        end

        // Backpressure: result held while the source keeps offering an element.
        run_vector(tbl[1], 1'b0);
        in_valid   = 1'b1;
        in_weight  = 5'd7;
        in_feature = 5'd7;
        for (int c = 0; c < 10; c++) begin
            step();
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_data", int'(out_data), 96);
        end
        in_valid = 1'b0;
        check("bp_vectors_untouched", int'(mult_product), 96);
        release_out();
        run_vector(tbl[2], 1'b1);

        // Reset in the middle of a fill discards everything.
        for (int i = 0; i < 50; i++) begin
            send(ELEM_W'(i), ELEM_W'(i + 1), 1'b0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_data", int'(out_data), 0);
        held = 0;
        for (int i = 0; i < VEC_LEN; i++) begin
            if (weight_vec[i] != '0 || feature_vec[i] != '0) held++;
        end
        check("mid_rst_nonzero_entries", held, 0);
        send(5'd2, 5'd3, 1'b0);
        send(5'd2, 5'd3, 1'b0);
        send(5'd2, 5'd3, 1'b1);
        check("post_rst_eval_in_ready", int'(in_ready), 0);
        step();
        check("post_rst_out_valid", int'(out_valid), 1);
        check("post_rst_out_data", int'(out_data), 18);
        check("post_rst_out_short", int'(out_short), 1);
        release_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
